irq_ctrl: RTL and testbench

Parametrised memory-mapped interrupt controller that replaces the single hard-wired timer IRQ readback with NUM_IRQ maskable channels. Each channel is configurable per bit:
- level- or edge-triggered;
- active-high or active-low.

Sticky pending bits are cleared by write-1-to-clear. A priority vector register and a single registered irq output feed the nano core. It sits on the core data bus beside the pio, timer and uart peripherals and uses the same read/write/waitrequest slave protocol.

---
 rtl/irq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// irq_ctrl - NUM_IRQ-channel maskable interrupt controller (level/edge, polarity,
// W1C pending, priority vector). Macro IRQ_CTRL_IRQ_SYNC_EN adds an input synchronizer.
// Rev 1.0
//------------------------------------------------------------------------------
module irq_ctrl #(
   parameter int NUM_IRQ  = 8,
   parameter int WIDTHD   = 16,
   parameter int ADDRBITS = 3
) (
   input  logic                clock,
   input  logic                sreset,
   input  logic [ADDRBITS-1:0] address,
   input  logic [WIDTHD-1:0]   writedata,
   output logic [WIDTHD-1:0]   readdata,
   input  logic                read,
   input  logic                write,
   output logic                waitrequest,
   input  logic [NUM_IRQ-1:0]  irq_in,
   output logic                irq
);

   localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [ADDRBITS-1:0] A_STATUS   = ADDRBITS'(0);
   localparam logic [ADDRBITS-1:0] A_PENDING  = ADDRBITS'(1);
   localparam logic [ADDRBITS-1:0] A_ENABLE   = ADDRBITS'(2);
   localparam logic [ADDRBITS-1:0] A_MODE     = ADDRBITS'(3);
   localparam logic [ADDRBITS-1:0] A_POLARITY = ADDRBITS'(4);
   localparam logic [ADDRBITS-1:0] A_VECTOR   = ADDRBITS'(5);

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   rd_state_t state_q, state_d;
   logic rd_capture;

   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] enable_q, enable_d;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
   logic [NUM_IRQ-1:0] polarity_q, polarity_d;
   logic [NUM_IRQ-1:0] hist_q;
   logic [NUM_IRQ-1:0] src, act, w1c, status, wd;
   logic [WIDTHD-1:0]  readdata_q, rdata, vec;
   logic [IDXW-1:0]    idx;
   logic               irq_q;

   assign wd = writedata[NUM_IRQ-1:0];

   generate
      if (NUM_IRQ < WIDTHD) begin : g_unused_wd
         logic unused_wd;
         assign unused_wd = ^writedata[WIDTHD-1:NUM_IRQ];
      end
   endgenerate

`ifdef IRQ_CTRL_IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] sync1_q, sync2_q;

   always_ff @(posedge clock or posedge sreset) begin
      if (sreset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_in;
         sync2_q <= sync1_q;
      end
   end

   assign src = sync2_q;
`else
   assign src = irq_in;
`endif

   // A read+write collision is treated as a plain write: no stall, no capture.
   always_comb begin
      state_d     = state_q;
      waitrequest = 1'b0;
      rd_capture  = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (read && !write) begin
               waitrequest = ~sreset;
               rd_capture  = 1'b1;
               state_d     = RD_DATA;
            end
         end
         RD_DATA: state_d = RD_IDLE;
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      act        = src ^ polarity_q;
      w1c        = (write && (address == A_PENDING)) ? wd : '0;
      // Edge channels: a fresh edge beats a same-cycle W1C; level channels follow act.
      pending_d  = (mode_q & ((act & ~hist_q) | (pending_q & ~w1c))) | (~mode_q & act);
      enable_d   = (write && (address == A_ENABLE))   ? wd : enable_q;
      mode_d     = (write && (address == A_MODE))     ? wd : mode_q;
      polarity_d = (write && (address == A_POLARITY)) ? wd : polarity_q;
   end

   assign status = pending_q & enable_q;

   always_comb begin
      idx   = '0;
      vec   = '0;
      rdata = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (status[i]) idx = IDXW'(i);
      end
      if (|status) begin
         vec[WIDTHD-1]  = 1'b1;
         vec[IDXW-1:0]  = idx;
      end
      case (address)
         A_STATUS:   rdata[NUM_IRQ-1:0] = status;
         A_PENDING:  rdata[NUM_IRQ-1:0] = pending_q;
         A_ENABLE:   rdata[NUM_IRQ-1:0] = enable_q;
         A_MODE:     rdata[NUM_IRQ-1:0] = mode_q;
         A_POLARITY: rdata[NUM_IRQ-1:0] = polarity_q;
         A_VECTOR:   rdata              = vec;
         default:    rdata              = '0;
      endcase
   end

   always_ff @(posedge clock or posedge sreset) begin
      if (sreset) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or posedge sreset) begin
      if (sreset) begin
         pending_q  <= '0;
         enable_q   <= '0;
         mode_q     <= '0;
         polarity_q <= '0;
         hist_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         polarity_q <= polarity_d;
         hist_q     <= act;
         irq_q      <= |status;
         if (rd_capture) readdata_q <= rdata;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_irq_ctrl - self-checking bench: vector table, hand sequences and random
// traffic against a behavioural model of the interrupt controller.
//------------------------------------------------------------------------------
module tb_irq_ctrl;

`ifdef IRQ_CTRL_IRQ_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 0;
`endif
   localparam int IRQ_LAT = 2 + SYNC_STAGES;

   logic        clock = 1'b0;
   logic        sreset = 1'b0;
   logic [2:0]  address = '0;
   logic [15:0] writedata = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [7:0]  irq_in = '0;
   logic [15:0] readdata;
   logic        waitrequest;
   logic        irq;

   irq_ctrl #(.NUM_IRQ(8), .WIDTHD(16), .ADDRBITS(3)) dut (
      .clock       (clock),
      .sreset      (sreset),
      .address     (address),
      .writedata   (writedata),
      .readdata    (readdata),
      .read        (read),
      .write       (write),
      .waitrequest (waitrequest),
      .irq_in      (irq_in),
      .irq         (irq)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input int step, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, step, got, exp);
      end
   endtask

   // Behavioural model: registers as the software sees them.
   logic [7:0]  m_pend, m_en, m_mode, m_pol, m_prev_act, m_s1, m_s2;
   logic        m_irq, m_busy;
   logic [15:0] m_rdata;
   wire  [7:0]  m_src;
`ifdef IRQ_CTRL_IRQ_SYNC_EN
   assign m_src = m_s2;
`else
   assign m_src = irq_in;
`endif
   wire  [7:0]  m_act = m_src ^ m_pol;

   function automatic logic [15:0] f_view(input logic [2:0] a);
      logic [7:0]  st;
      logic [15:0] v;
      st = m_pend & m_en;
      v  = 16'h0000;
      case (a)
         3'd0: v = {8'h00, st};
         3'd1: v = {8'h00, m_pend};
         3'd2: v = {8'h00, m_en};
         3'd3: v = {8'h00, m_mode};
         3'd4: v = {8'h00, m_pol};
         3'd5: for (int i = 7; i >= 0; i--) if (st[i]) v = 16'h8000 | 16'(i);
         default: v = 16'h0000;
      endcase
      return v;
   endfunction

   always @(posedge clock or posedge sreset) begin
      if (sreset) begin
         m_pend <= '0; m_en <= '0; m_mode <= '0; m_pol <= '0; m_prev_act <= '0;
         m_s1 <= '0; m_s2 <= '0; m_irq <= 1'b0; m_busy <= 1'b0; m_rdata <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (m_mode[i])
               m_pend[i] <= (m_act[i] && !m_prev_act[i]) ||
                            (m_pend[i] && !(write && address == 3'd1 && writedata[i]));
            else
               m_pend[i] <= m_act[i];
         end
         m_prev_act <= m_act;
         if (write && address == 3'd2) m_en   <= writedata[7:0];
         if (write && address == 3'd3) m_mode <= writedata[7:0];
         if (write && address == 3'd4) m_pol  <= writedata[7:0];
         m_irq <= |(m_pend & m_en);
         if (read && !write && !m_busy) m_rdata <= f_view(address);
         m_busy <= read && !write && !m_busy;
         m_s1 <= irq_in;
         m_s2 <= m_s1;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("model_irq", -1, irq, m_irq);
         check("model_readdata", -1, readdata, m_rdata);
         check("model_waitrequest", -1, waitrequest, read && !write && !m_busy && !sreset);
      end
   end

   // One table entry = one clock cycle of bus/irq_in activity.
   typedef struct {
      logic        we, re;
      logic [2:0]  addr;
      logic [15:0] wd;
      logic [7:0]  iq;
      logic        cw, ew, ci, ei, cr;
      logic [15:0] er;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic we, re, input logic [2:0] a, input logic [15:0] d,
                               input logic [7:0] iq, input logic cw, ew, ci, ei, cr,
                               input logic [15:0] er);
      vec_t v;
      v.we = we; v.re = re; v.addr = a; v.wd = d; v.iq = iq;
      v.cw = cw; v.ew = ew; v.ci = ci; v.ei = ei; v.cr = cr; v.er = er;
      return v;
   endfunction

   task automatic t_wr(input logic [2:0] a, input logic [15:0] d, input logic [7:0] iq,
                       input logic ci, input logic ei);
      tbl.push_back(mk(1'b1, 1'b0, a, d, iq, 1'b1, 1'b0, ci, ei, 1'b0, 16'h0));
   endtask

   task automatic t_idle(input logic [7:0] iq, input logic ci, input logic ei);
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0, iq, 1'b1, 1'b0, ci, ei, 1'b0, 16'h0));
   endtask

   task automatic t_rd(input logic [2:0] a, input logic [7:0] iq, input logic [15:0] exp);
      tbl.push_back(mk(1'b0, 1'b1, a, 16'h0, iq, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp));
      tbl.push_back(mk(1'b0, 1'b1, a, 16'h0, iq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp));
   endtask

   task automatic do_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clock); #1;
      write = 1'b1; read = 1'b0; address = a; writedata = d;
      @(negedge clock); #1;
      write = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input string nm);
      @(negedge clock); #1;
      read = 1'b1; write = 1'b0; address = a;
      #1 check({nm, "_wait1"}, 0, waitrequest, 1);
      @(negedge clock); #1;
      check(nm, 0, readdata, exp);
      check({nm, "_wait2"}, 0, waitrequest, 0);
      @(negedge clock); #1;
      read = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 sreset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check("rst_readdata", 0, readdata, 0);
      check("rst_irq", 0, irq, 0);
      check("rst_wait", 0, waitrequest, 0);
      sreset = 1'b0;
      chk_en = 1'b1;

`ifndef IRQ_CTRL_IRQ_SYNC_EN
      // Edge channel 2
      t_wr(3'd3, 16'h0004, 8'h00, 1'b0, 1'b0);
      t_wr(3'd2, 16'h0004, 8'h00, 1'b0, 1'b0);
      t_idle(8'h04, 1'b1, 1'b0);
      t_idle(8'h00, 1'b1, 1'b1);
      t_rd(3'd1, 8'h00, 16'h0004);
      t_rd(3'd5, 8'h00, 16'h8002);
      t_wr(3'd1, 16'h0004, 8'h00, 1'b1, 1'b1);
      t_idle(8'h00, 1'b1, 1'b0);
      t_rd(3'd1, 8'h00, 16'h0000);
      // Level, active-low channel 0
      t_wr(3'd3, 16'h0000, 8'h00, 1'b0, 1'b0);
      t_wr(3'd2, 16'h0001, 8'h00, 1'b0, 1'b0);
      t_wr(3'd4, 16'h0001, 8'h00, 1'b0, 1'b0);
      t_idle(8'h01, 1'b1, 1'b0);
      t_idle(8'h00, 1'b1, 1'b0);
      t_idle(8'h00, 1'b1, 1'b1);
      t_wr(3'd1, 16'h0001, 8'h00, 1'b1, 1'b1);
      t_rd(3'd1, 8'h00, 16'h0001);
      t_idle(8'h01, 1'b1, 1'b1);
      t_rd(3'd1, 8'h01, 16'h0000);
      t_idle(8'h01, 1'b1, 1'b0);
      // Priority and masking: edges on 1, 5, 6
      t_wr(3'd4, 16'h0000, 8'h01, 1'b0, 1'b0);
      t_wr(3'd3, 16'h0062, 8'h00, 1'b0, 1'b0);
      t_wr(3'd2, 16'h0060, 8'h00, 1'b0, 1'b0);
      t_idle(8'h62, 1'b1, 1'b0);
      t_idle(8'h00, 1'b1, 1'b1);
      t_rd(3'd0, 8'h00, 16'h0060);
      t_rd(3'd5, 8'h00, 16'h8005);
      t_rd(3'd1, 8'h00, 16'h0062);
      // Set/clear collision on channel 3
      t_wr(3'd3, 16'h0008, 8'h00, 1'b0, 1'b0);
      t_idle(8'h00, 1'b0, 1'b0);
      t_wr(3'd1, 16'h0008, 8'h08, 1'b0, 1'b0);
      t_rd(3'd1, 8'h00, 16'h0008);
      // Bus protocol and register map edges
      t_rd(3'd7, 8'h00, 16'h0000);
      tbl.push_back(mk(1'b1, 1'b1, 3'd2, 16'h00AA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
      t_rd(3'd2, 8'h00, 16'h00AA);
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AA));
      t_wr(3'd2, 16'hFF55, 8'h00, 1'b0, 1'b0);
      t_rd(3'd2, 8'h00, 16'h0055);
      t_wr(3'd6, 16'hFFFF, 8'h00, 1'b0, 1'b0);
      t_rd(3'd6, 8'h00, 16'h0000);
      t_wr(3'd0, 16'h00FF, 8'h00, 1'b0, 1'b0);
      t_rd(3'd3, 8'h00, 16'h0008);

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clock); #1;
         write = tbl[k].we; read = tbl[k].re; address = tbl[k].addr;
         writedata = tbl[k].wd; irq_in = tbl[k].iq;
         #1 if (tbl[k].cw) check("tbl_wait", k, waitrequest, tbl[k].ew);
         @(posedge clock); #2;
         if (tbl[k].ci) check("tbl_irq", k, irq, tbl[k].ei);
         if (tbl[k].cr) check("tbl_readdata", k, readdata, tbl[k].er);
      end
      @(negedge clock); #1;
      write = 1'b0; read = 1'b0; irq_in = 8'h00;
`endif

      // Reset in the middle of an access with everything pending and enabled
      do_write(3'd4, 16'h0000);
      do_write(3'd3, 16'h00FF);
      do_write(3'd2, 16'h00FF);
      @(negedge clock); #1 irq_in = 8'hFF;
      @(negedge clock); #1 irq_in = 8'h00;
      repeat (4) @(negedge clock);
      do_read(3'd1, 16'h00FF, "pre_rst_pending");
      @(negedge clock); #1;
      check("pre_rst_irq", 0, irq, 1);
      read = 1'b1; address = 3'd0;
      #1 sreset = 1'b1;
      #1;
      check("midrst_readdata", 0, readdata, 0);
      check("midrst_irq", 0, irq, 0);
      check("midrst_wait", 0, waitrequest, 0);
      @(negedge clock); #1;
      sreset = 1'b0; read = 1'b0;
      do_read(3'd0, 16'h0000, "post_rst_status");
      do_read(3'd1, 16'h0000, "post_rst_pending");
      do_read(3'd2, 16'h0000, "post_rst_enable");
      do_read(3'd3, 16'h0000, "post_rst_mode");

      // Edge-to-irq latency, then W1C drop
      do_write(3'd3, 16'h0004);
      do_write(3'd2, 16'h0004);
      @(negedge clock); #1 irq_in = 8'h04;
      @(negedge clock); #1 irq_in = 8'h00;
      for (int c = 0; c < 6; c++) begin
         check("lat_irq", c, irq, (c >= IRQ_LAT - 1) ? 1 : 0);
         @(negedge clock); #1;
      end
      do_read(3'd5, 16'h8002, "lat_vector");
      do_write(3'd1, 16'h0004);
      check("w1c_irq_hold", 0, irq, 1);
      @(negedge clock); #1;
      check("w1c_irq_drop", 0, irq, 0);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int r;
         @(negedge clock); #1;
         if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
         r = $urandom_range(0, 9);
         write = (r < 3) || (r == 9);
         read  = (r >= 3 && r < 6) || (r == 9);
         address = 3'($urandom);
         writedata = 16'($urandom);
      end
      @(negedge clock); #1;
      write = 1'b0; read = 1'b0;
      repeat (3) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
